sb_tx_scheduler: RTL

//  Shares the sideband serializer between NUM_REQ on-die message sources (LTSM, register access, link mgmt).

---
 rtl/sb_pkg.sv | 16 +
 rtl/sb_tx_scheduler_if.sv | 24 ++
 rtl/sb_rr_arbiter.sv | 34 +++
 rtl/sb_tx_scheduler.sv | 112 +++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared types and timing constants for the sideband TX scheduler.
package sb_pkg;

  typedef enum logic [1:0] {
    SCH_IDLE  = 2'd0,
    SCH_ISSUE = 2'd1,
    SCH_GAP   = 2'd2
  } sch_state_t;

  localparam int SB_PKT_BITS    = 64;
  localparam int SB_DATA_CYCLES = 64;
  localparam int SB_GAP_CYCLES  = 32;
  // One IDLE->TX cycle, the data beats, then the mandatory post-packet gap.
  localparam int SB_PKT_CYCLES  = 1 + SB_DATA_CYCLES + SB_GAP_CYCLES;

endpackage

// File: rtl/sb_tx_scheduler_if.sv
// Packet handshake between the scheduler (master) and the sideband serializer (slave).
interface sb_tx_scheduler_if;
  import sb_pkg::*;

  logic [SB_PKT_BITS-1:0] tx_data_o;
  logic                   tx_valid_o;
  logic                   tx_ack_i;
  logic                   tx_enable_o;

  modport master (
    output tx_data_o,
    output tx_valid_o,
    output tx_enable_o,
    input  tx_ack_i
  );

  modport slave (
    input  tx_data_o,
    input  tx_valid_o,
    input  tx_enable_o,
    output tx_ack_i
  );

endinterface

// File: rtl/sb_rr_arbiter.sv
// Combinational round-robin pick: rotate requests so ptr sits at bit 0,
// take the lowest set bit, then rotate the index back.
module sb_rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [2*N-1:0]   req_dbl;
  logic [N-1:0]     req_rot;
  logic [IDX_W-1:0] offset;
  logic [IDX_W:0]   sum;

  assign req_dbl   = {req, req};
  assign req_rot   = N'(req_dbl >> ptr);
  assign gnt_valid = |req;

  // Priority-encode the rotated vector and map the offset back to a requester index.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = IDX_W'(i);
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (IDX_W + 1)'(N)) gnt_idx = IDX_W'(sum - (IDX_W + 1)'(N));
    else                        gnt_idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/sb_tx_scheduler.sv
// Shares the sideband serializer between NUM_REQ message sources. Round-robin
// grants one 64-bit packet at a time and paces issue with a credit counter that
// models the serializer's buffer drain, since that buffer has no full flag.
module sb_tx_scheduler
  import sb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int BUF_DEPTH  = 4,
  parameter int PKT_CYCLES = SB_PKT_CYCLES
) (
  input  logic                           clk_800MHz,
  input  logic                           reset,
  input  logic                           link_en_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*SB_PKT_BITS-1:0] req_data_i,
  output logic [NUM_REQ-1:0]             req_ack_o,
  sb_tx_scheduler_if.master              ser,
  output logic [$clog2(BUF_DEPTH):0]     credits_o,
  output logic                           busy_o
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int CRED_W = $clog2(BUF_DEPTH) + 1;
  localparam int CTR_W  = $clog2(PKT_CYCLES);

  localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(BUF_DEPTH);
  localparam logic [CTR_W-1:0]  CTR_LAST  = CTR_W'(PKT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REQ - 1);

  sch_state_t        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_valid;
  logic [CRED_W-1:0] credits;
  logic [CTR_W-1:0]  drain_ctr;
  logic              take_credit;
  logic              return_credit;

  sb_rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (req_valid_i),
    .ptr       (rr_ptr),
    .gnt_valid (arb_valid),
    .gnt_idx   (arb_idx)
  );

  // A credit is consumed on acceptance and returned once the modelled drain of one packet completes.
  assign take_credit   = (state == SCH_ISSUE) && ser.tx_ack_i;
  assign return_credit = (credits != CRED_FULL) && (drain_ctr == CTR_LAST);

  assign credits_o = credits;
  assign busy_o    = (credits != CRED_FULL) || (state != SCH_IDLE);

  // Grant/offer/gap sequencing; the offer is held until the serializer accepts it.
  always_ff @(posedge clk_800MHz) begin
    if (reset) begin
      state          <= SCH_IDLE;
      rr_ptr         <= '0;
      grant_idx      <= '0;
      ser.tx_valid_o <= 1'b0;
      ser.tx_data_o  <= '0;
      req_ack_o      <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees pre-edge values and later writes override earlier defaults.
      req_ack_o <= '0;
      unique case (state)
        SCH_IDLE: begin
          if (link_en_i && arb_valid && (credits != '0)) begin
            grant_idx      <= arb_idx;
            ser.tx_data_o  <= req_data_i[arb_idx*SB_PKT_BITS +: SB_PKT_BITS];
            ser.tx_valid_o <= 1'b1;
            state          <= SCH_ISSUE;
          end
        end
        SCH_ISSUE: begin
          if (ser.tx_ack_i) begin
            ser.tx_valid_o       <= 1'b0;
            req_ack_o[grant_idx] <= 1'b1;
            rr_ptr               <= (grant_idx == IDX_LAST) ? '0 : grant_idx + IDX_W'(1);
            state                <= SCH_GAP;
          end
        end
        SCH_GAP:  state <= SCH_IDLE;
        default:  state <= SCH_IDLE;
      endcase
    end
  end

  // Buffer-write enable trails link_en_i by one cycle.
  always_ff @(posedge clk_800MHz) begin
    if (reset) ser.tx_enable_o <= 1'b0;
    else       ser.tx_enable_o <= link_en_i;
  end

  // Credit counter plus drain timer; simultaneous take and return leave credits unchanged.
  always_ff @(posedge clk_800MHz) begin
    if (reset) begin
      credits   <= CRED_FULL;
      drain_ctr <= '0;
    end else begin
      if (take_credit && !return_credit)      credits <= credits - CRED_W'(1);
      else if (return_credit && !take_credit) credits <= credits + CRED_W'(1);

      if ((credits == CRED_FULL) || return_credit) drain_ctr <= '0;
      else                                         drain_ctr <= drain_ctr + CTR_W'(1);
    end
  end

endmodule
